// File: rtl/ifft_8_seq_pkg.sv
// rtl/ifft_8_seq_pkg.sv - shared constants, types and schedule for ifft_8_seq
package ifft_8_seq_pkg;

  localparam logic [31:0] ONE  = 32'h3f800000;
  localparam logic [31:0] ZERO = 32'h00000000;
  localparam logic [31:0] C707 = 32'h3f34fdf4;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] w;
  } sched_t;

  localparam cplx_t TW_FWD [4] = '{
    {ONE, ZERO},
    {C707, {1'b1, C707[30:0]}},
    {ZERO, {1'b1, ONE[30:0]}},
    {{1'b1, C707[30:0]}, {1'b1, C707[30:0]}}
  };

  // Zero imaginary parts stay +0 so W0 conjugates to itself bit-for-bit
  function automatic cplx_t conj(input cplx_t c);
    return {c.re, c.im[31] ^ (c.im[30:0] != 31'd0), c.im[30:0]};
  endfunction

  localparam cplx_t TW_INV [4] = '{
    conj(TW_FWD[0]), conj(TW_FWD[1]), conj(TW_FWD[2]), conj(TW_FWD[3])
  };

  function automatic sched_t sched_rom(input logic [3:0] s);
    case (s)
      4'd0:    return {3'd0, 3'd1, 2'd0};
      4'd1:    return {3'd2, 3'd3, 2'd0};
      4'd2:    return {3'd4, 3'd5, 2'd0};
      4'd3:    return {3'd6, 3'd7, 2'd0};
      4'd4:    return {3'd0, 3'd2, 2'd0};
      4'd5:    return {3'd1, 3'd3, 2'd2};
      4'd6:    return {3'd4, 3'd6, 2'd0};
      4'd7:    return {3'd5, 3'd7, 2'd2};
      4'd8:    return {3'd0, 3'd4, 2'd0};
      4'd9:    return {3'd1, 3'd5, 2'd1};
      4'd10:   return {3'd2, 3'd6, 2'd2};
      4'd11:   return {3'd3, 3'd7, 2'd3};
      default: return {3'd0, 3'd1, 2'd0};
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft_8_seq_if.sv
// rtl/ifft_8_seq_if.sv - sample-in / sample-out handshake bundle for ifft_8_seq
interface ifft_8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic        out_last;
  logic        busy;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last, busy
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last, busy
  );
endinterface

// File: rtl/bfly4_4.sv
// rtl/bfly4_4.sv - combinational radix-2 complex butterfly: A+W*B, A-W*B
module bfly4_4
  import ifft_8_seq_pkg::*;
(
  input  cplx_t i_a,
  input  cplx_t i_b,
  input  cplx_t i_w,
  output cplx_t o_a,
  output cplx_t o_b
);
  logic [31:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir, w_t_re, w_t_im;
  logic [31:0] w_a_re, w_a_im, w_b_re, w_b_im;

  multiplication u_m_rr (.i_a(i_w.re), .i_b(i_b.re), .o_y(w_p_rr));
  multiplication u_m_ii (.i_a(i_w.im), .i_b(i_b.im), .o_y(w_p_ii));
  multiplication u_m_ri (.i_a(i_w.re), .i_b(i_b.im), .o_y(w_p_ri));
  multiplication u_m_ir (.i_a(i_w.im), .i_b(i_b.re), .o_y(w_p_ir));

  Addition_Subtraction u_t_re (.i_a(w_p_rr), .i_b(w_p_ii), .i_sub(1'b1), .o_y(w_t_re));
  Addition_Subtraction u_t_im (.i_a(w_p_ri), .i_b(w_p_ir), .i_sub(1'b0), .o_y(w_t_im));
  Addition_Subtraction u_a_re (.i_a(i_a.re), .i_b(w_t_re), .i_sub(1'b0), .o_y(w_a_re));
  Addition_Subtraction u_a_im (.i_a(i_a.im), .i_b(w_t_im), .i_sub(1'b0), .o_y(w_a_im));
  Addition_Subtraction u_b_re (.i_a(i_a.re), .i_b(w_t_re), .i_sub(1'b1), .o_y(w_b_re));
  Addition_Subtraction u_b_im (.i_a(i_a.im), .i_b(w_t_im), .i_sub(1'b1), .o_y(w_b_im));

  assign o_a = {w_a_re, w_a_im};
  assign o_b = {w_b_re, w_b_im};
endmodule

// File: rtl/fp_scale_pow2.sv
// rtl/fp_scale_pow2.sv - optional divide-by-8 of a float32 via exponent adjust
module fp_scale_pow2 #(
  parameter bit SCALE_EN = 1'b1
) (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);
  always_comb begin
    o_y = i_x;
    // Inf/NaN pass through; anything that would go subnormal flushes to signed zero
    if (SCALE_EN && i_x[30:23] != 8'hff) begin
      if (i_x[30:23] <= 8'd3) o_y = {i_x[31], 31'd0};
      else o_y = {i_x[31], i_x[30:23] - 8'd3, i_x[22:0]};
    end
  end
endmodule

// File: rtl/fp_units.sv
// rtl/fp_units.sv - float32 multiplication and Addition_Subtraction units
// Denormals are treated as zero; results round to nearest-even.
module multiplication (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [47:0] w_p;
  logic [9:0]  w_e;
  logic [22:0] w_m;
  logic        w_s, w_g, w_st, w_rnd;

  always_comb begin
    w_s = i_a[31] ^ i_b[31];
    w_p = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
    w_e = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} + {9'd0, w_p[47]} - 10'd127;
    if (w_p[47]) begin
      w_m = w_p[46:24]; w_g = w_p[23]; w_st = |w_p[22:0];
    end else begin
      w_m = w_p[45:23]; w_g = w_p[22]; w_st = |w_p[21:0];
    end
    w_rnd = w_g & (w_st | w_m[0]);
    // A negative biased exponent wraps and lands with bit 9 set
    if (i_a[30:23] == 8'hff || i_b[30:23] == 8'hff) o_y = {w_s, 8'hff, 23'd0};
    else if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0 || w_e[9] || w_e == 10'd0)
      o_y = {w_s, 31'd0};
    else if (w_e >= 10'd255) o_y = {w_s, 8'hff, 23'd0};
    else o_y = {w_s, {w_e[7:0], w_m} + {30'd0, w_rnd}};
  end
endmodule

module Addition_Subtraction (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_y
);
  logic [31:0] w_bs, w_big, w_sml;
  logic [7:0]  w_d;
  logic [26:0] w_mb, w_ms, w_sum, w_norm;
  logic [4:0]  w_lz;
  logic [8:0]  w_e;
  logic        w_rnd;

  always_comb begin
    w_bs = {i_b[31] ^ i_sub, i_b[30:0]};
    if (i_a[30:0] >= w_bs[30:0]) begin
      w_big = i_a;  w_sml = w_bs;
    end else begin
      w_big = w_bs; w_sml = i_a;
    end
    w_d   = w_big[30:23] - w_sml[30:23];
    w_mb  = {1'b0, |w_big[30:23], w_big[22:0], 2'b00};
    w_ms  = {1'b0, |w_sml[30:23], w_sml[22:0], 2'b00} >> w_d;
    w_sum = (w_big[31] == w_sml[31]) ? w_mb + w_ms : w_mb - w_ms;
    w_lz  = 5'd0;
    for (int i = 0; i < 27; i++) if (w_sum[i]) w_lz = 5'(26 - i);
    w_norm = w_sum << w_lz;
    w_rnd  = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_e    = {1'b0, w_big[30:23]} + 9'd1 - {4'd0, w_lz};
    if (w_big[30:23] == 8'hff) o_y = w_big;
    else if (!w_norm[26]) o_y = 32'd0;
    else if (w_e[8] || w_e == 9'd0) o_y = {w_big[31], 31'd0};
    else if (w_e == 9'd255) o_y = {w_big[31], 8'hff, 23'd0};
    else o_y = {w_big[31], {w_e[7:0], w_norm[25:3]} + {30'd0, w_rnd}};
  end
endmodule

// File: rtl/ifft_8_seq.sv
// rtl/ifft_8_seq.sv - sequential 8-point inverse FFT on float32 complex samples
module ifft_8_seq
  import ifft_8_seq_pkg::*;
#(
  parameter bit SCALE_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  ifft_8_seq_if.slave bus
);
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  cplx_t       r_bank [8];
  logic        r_out_valid, r_out_last;
  logic [31:0] r_out_re, r_out_im;
  logic        w_in_ready, w_hs_in, w_hs_out, w_last_step;
  logic [2:0]  w_rd_idx;
  sched_t      w_sch;
  cplx_t       w_a_new, w_b_new, w_rd;
  logic [31:0] w_sc_re, w_sc_im;

  assign w_in_ready  = (r_state == LOAD) && !rst;
  assign w_hs_in     = bus.in_valid && w_in_ready;
  assign w_hs_out    = r_out_valid && bus.out_ready;
  assign w_last_step = (r_state == COMPUTE) && (r_cnt == 4'd11);
  assign w_sch       = sched_rom(r_cnt);
  // Pre-fetch x[0] on the last compute step, otherwise the sample after the current one
  assign w_rd_idx    = (r_state == OUTPUT) ? r_cnt[2:0] + 3'd1 : 3'd0;
  assign w_rd        = r_bank[w_rd_idx];

  bfly4_4 u_bfly (
    .i_a(r_bank[w_sch.a]), .i_b(r_bank[w_sch.b]), .i_w(TW_INV[w_sch.w]),
    .o_a(w_a_new), .o_b(w_b_new)
  );

  fp_scale_pow2 #(.SCALE_EN(SCALE_EN)) u_sc_re (.i_x(w_rd.re), .o_y(w_sc_re));
  fp_scale_pow2 #(.SCALE_EN(SCALE_EN)) u_sc_im (.i_x(w_rd.im), .o_y(w_sc_im));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOAD: if (w_hs_in) begin
        if (r_cnt == 4'd7) begin w_state_nxt = COMPUTE; w_cnt_nxt = 4'd0; end
        else w_cnt_nxt = r_cnt + 4'd1;
      end
      COMPUTE: begin
        if (r_cnt == 4'd11) begin w_state_nxt = OUTPUT; w_cnt_nxt = 4'd0; end
        else w_cnt_nxt = r_cnt + 4'd1;
      end
      OUTPUT: if (w_hs_out) begin
        if (r_cnt == 4'd7) begin w_state_nxt = LOAD; w_cnt_nxt = 4'd0; end
        else w_cnt_nxt = r_cnt + 4'd1;
      end
      default: begin w_state_nxt = LOAD; w_cnt_nxt = 4'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_hs_in) begin
      r_bank[bitrev3(r_cnt[2:0])] <= {bus.in_re, bus.in_im};
    end else if (r_state == COMPUTE && !rst) begin
      r_bank[w_sch.a] <= w_a_new;
      r_bank[w_sch.b] <= w_b_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= 32'd0;
      r_out_im    <= 32'd0;
    end else if (w_last_step) begin
      r_out_valid <= 1'b1;
      r_out_last  <= 1'b0;
      r_out_re    <= w_sc_re;
      r_out_im    <= w_sc_im;
    end else if (w_hs_out) begin
      if (r_cnt == 4'd7) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_out_re   <= w_sc_re;
        r_out_im   <= w_sc_im;
        r_out_last <= (r_cnt == 4'd6);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != LOAD);
endmodule

// File: tb/tb_ifft_8_seq.sv
// tb/tb_ifft_8_seq.sv - directed self-checking bench for ifft_8_seq
module tb_ifft_8_seq;
  localparam logic [31:0] F_ONE = 32'h3f800000;
  localparam logic [31:0] F_EIGHTH = 32'h3e000000;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft_8_seq_if bus1 ();
  ifft_8_seq_if bus0 ();

  // Unscaled instance sees exactly the same stimulus as the scaled one
  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.in_re     = bus1.in_re;
  assign bus0.in_im     = bus1.in_im;
  assign bus0.out_ready = bus1.out_ready;

  ifft_8_seq #(.SCALE_EN(1'b1)) u_dut    (.clk(clk), .rst(rst), .bus(bus1.slave));
  ifft_8_seq #(.SCALE_EN(1'b0)) u_dut_ns (.clk(clk), .rst(rst), .bus(bus0.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [31:0] x_re [8], x_im [8];
  logic [31:0] y_re [8], y_im [8], y_re_ns [8];

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    m = m * (2.0 ** e);
    return f[31] ? -m : m;
  endfunction

  task automatic check(input string tag, input real got, input real exp, input real tol);
    n_cmp++;
    if (got - exp > tol || exp - got > tol) begin
      n_bad++;
      $display("FAIL %s: got %g, expected %g", tag, got, exp);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      x_re[k] = 32'd0;
      x_im[k] = 32'd0;
    end
  endtask

  // Returns just after the 8th accepting edge, leaving junk on in_valid to prove it is ignored
  task automatic send_frame();
    int wait_n;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_re = x_re[k];
      bus1.in_im = x_im[k];
      wait_n = 0;
      while (!bus1.in_ready && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      if (!bus1.in_ready) check("in_ready_timeout", 0.0, 1.0, 0.0);
      @(posedge clk);
    end
    #1;
    bus1.in_re = 32'h40400000;
    bus1.in_im = 32'hc0000000;
  endtask

  task automatic collect(input int stall_at);
    int budget;
    bus1.out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus1.out_valid && lat < 40);
    check("latency", real'(lat), 13.0, 0.0);
    for (int n = 0; n < 8; n++) begin
      budget = 0;
      while (!bus1.out_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check($sformatf("out_valid[%0d]", n), real'(bus1.out_valid), 1.0, 0.0);
      check($sformatf("out_last[%0d]", n), real'(bus1.out_last), (n == 7) ? 1.0 : 0.0, 0.0);
      check($sformatf("in_ready_out[%0d]", n), real'(bus1.in_ready), 0.0, 0.0);
      y_re[n] = bus1.out_re;
      y_im[n] = bus1.out_im;
      y_re_ns[n] = bus0.out_re;
      if (n == stall_at) begin
        bus1.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_valid", real'(bus1.out_valid), 1.0, 0.0);
          check("stall_re", real'(bus1.out_re), real'(F_EIGHTH), 0.0);
          check("stall_im", f2r(bus1.out_im), 0.0, 0.0);
          check("stall_last", real'(bus1.out_last), 0.0, 0.0);
          check("stall_in_ready", real'(bus1.in_ready), 0.0, 0.0);
        end
        bus1.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("end_valid", real'(bus1.out_valid), 0.0, 0.0);
    check("end_in_ready", real'(bus1.in_ready), 1.0, 0.0);
    bus1.in_valid = 1'b0;
  endtask

  task automatic check_impulse(input string tag);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s_re[%0d]", tag, n), real'(y_re[n]), real'(F_EIGHTH), 0.0);
      check($sformatf("%s_im[%0d]", tag, n), f2r(y_im[n]), 0.0, 0.0);
      check($sformatf("%s_re_ns[%0d]", tag, n), real'(y_re_ns[n]), real'(F_ONE), 0.0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_re = 32'd0;
    bus1.in_im = 32'd0;
    bus1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", real'(bus1.in_ready), 0.0, 0.0);
    check("rst_out_valid", real'(bus1.out_valid), 0.0, 0.0);
    check("rst_out_last", real'(bus1.out_last), 0.0, 0.0);
    check("rst_out_re", real'(bus1.out_re), 0.0, 0.0);
    check("rst_out_im", real'(bus1.out_im), 0.0, 0.0);
    check("rst_busy", real'(bus1.busy), 0.0, 0.0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", real'(bus1.in_ready), 1.0, 0.0);

    // Impulse with a 5-cycle stall at n=3
    clear_frame();
    x_re[0] = F_ONE;
    send_frame();
    collect(3);
    check_impulse("imp");

    // DC: everything lands in x[0]
    clear_frame();
    for (int k = 0; k < 8; k++) x_re[k] = F_ONE;
    send_frame();
    collect(-1);
    check("dc_re[0]", real'(y_re[0]), real'(F_ONE), 0.0);
    check("dc_im[0]", f2r(y_im[0]), 0.0, 1e-6);
    for (int n = 1; n < 8; n++) begin
      check($sformatf("dc_re[%0d]", n), f2r(y_re[n]), 0.0, 1e-6);
      check($sformatf("dc_im[%0d]", n), f2r(y_im[n]), 0.0, 1e-6);
    end

    // Single bin X1: x[n] = e^{+j*2*pi*n/8} / 8
    clear_frame();
    x_re[1] = F_ONE;
    send_frame();
    collect(-1);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("bin_re[%0d]", n), f2r(y_re[n]), 0.125 * $cos(PI * n / 4.0),
            (n == 2) ? 1e-6 : 1e-3);
      check($sformatf("bin_im[%0d]", n), f2r(y_im[n]), 0.125 * $sin(PI * n / 4.0),
            (n == 2) ? 1e-6 : 1e-3);
    end

    // Reset while the butterfly is on step 6
    clear_frame();
    for (int k = 0; k < 8; k++) x_re[k] = F_ONE;
    send_frame();
    repeat (7) @(negedge clk);
    check("mid_busy", real'(bus1.busy), 1.0, 0.0);
    rst = 1'b1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", real'(bus1.out_valid), 0.0, 0.0);
    check("mid_rst_in_ready", real'(bus1.in_ready), 1.0, 0.0);
    check("mid_rst_busy", real'(bus1.busy), 0.0, 0.0);
    clear_frame();
    x_re[0] = F_ONE;
    send_frame();
    collect(-1);
    check_impulse("imp2");

    // Smallest normal input flushes to zero once divided by 8
    clear_frame();
    x_re[0] = 32'h00800000;
    send_frame();
    collect(-1);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("flush_re[%0d]", n), real'(y_re[n]), 0.0, 0.0);
      check($sformatf("flush_re_ns[%0d]", n), real'(y_re_ns[n]), real'(32'h00800000), 0.0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
